// File: rtl/display_scan_decoder_if.sv
// Bus bundle for the multiplexed seven-segment scan: active-low digit select and
// segments in, decoded/verified frame state out.
interface display_scan_decoder_if;
    logic [7:0] control;
    logic [7:0] value;
    logic [5:0] johnson;
    logic [3:0] count;
    logic       frame_valid;
    logic       frame_err;
    logic [1:0] err_type;
    logic       stale;

    modport master (
        output control, value,
        input  johnson, count, frame_valid, frame_err, err_type, stale
    );

    modport slave (
        input  control, value,
        output johnson, count, frame_valid, frame_err, err_type, stale
    );
endinterface

// File: rtl/display_scan_decoder.sv
// Loopback monitor for the 8-digit scanned display: debounces digits, decodes segments,
// rebuilds the Johnson state and decimal count, and cross-checks the two.
module display_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned TIMEOUT       = 50000
) (
    input logic                   clock,
    input logic                   reset,
    display_scan_decoder_if.slave bus
);
    localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {HUNT, COLLECT, CHECK} state_t;

    state_t         r_state, w_next;
    logic [15:0]    r_samp;
    logic [SW-1:0]  r_stab;
    logic [3:0]     r_last_idx;
    logic [TW-1:0]  r_to;
    logic           r_stale_d;
    logic [5:0]     r_jc;
    logic [3:0]     r_units, r_tens;
    logic           r_bad;
    logic [2:0]     r_exp;
    logic [5:0]     r_jc_out;
    logic [3:0]     r_cnt_out;
    logic           r_fv, r_fe;
    logic [1:0]     r_err;

    logic [7:0]     w_sel;
    logic           w_onehot;
    logic [2:0]     w_idx;
    logic           w_accept;
    logic [4:0]     w_dec;
    logic           w_dig_ok;
    logic           w_stale, w_stale_rise;
    logic           w_start, w_store, w_seq_err, w_do_check;
    logic [7:0]     w_sum;
    logic           w_jc_legal;
    logic [1:0]     w_chk_err;

    // Returns {valid, numeral}; dp is not part of the pattern.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        case (s)
            7'h40:   return {1'b1, 4'd0};
            7'h79:   return {1'b1, 4'd1};
            7'h24:   return {1'b1, 4'd2};
            7'h30:   return {1'b1, 4'd3};
            7'h19:   return {1'b1, 4'd4};
            7'h12:   return {1'b1, 4'd5};
            7'h02:   return {1'b1, 4'd6};
            7'h78:   return {1'b1, 4'd7};
            7'h00:   return {1'b1, 4'd8};
            7'h10:   return {1'b1, 4'd9};
            default: return 5'b0;
        endcase
    endfunction

    function automatic logic [5:0] jc_of(input logic [3:0] n);
        case (n)
            4'd0:    return 6'b000000;
            4'd1:    return 6'b000001;
            4'd2:    return 6'b000011;
            4'd3:    return 6'b000111;
            4'd4:    return 6'b001111;
            4'd5:    return 6'b011111;
            4'd6:    return 6'b111111;
            4'd7:    return 6'b111110;
            4'd8:    return 6'b111100;
            4'd9:    return 6'b111000;
            4'd10:   return 6'b110000;
            4'd11:   return 6'b100000;
            default: return 6'b000000;
        endcase
    endfunction

    // Single input register; the stability count includes the sample just captured.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_samp <= '1;
            r_stab <= '0;
        end else begin
            r_samp <= {bus.control, bus.value};
            if ({bus.control, bus.value} != r_samp)
                r_stab <= SW'(1);
            else if (r_stab != SW'(STABLE_CYCLES))
                r_stab <= r_stab + 1'b1;
        end
    end

    assign w_sel    = ~r_samp[15:8];
    assign w_onehot = $onehot(w_sel);

    always_comb begin
        w_idx = '0;
        for (int unsigned k = 0; k < 8; k++)
            if (w_sel[k]) w_idx = 3'(k);
    end

    // r_last_idx of 8 means nothing accepted yet, so any first digit qualifies.
    assign w_accept = w_onehot && (r_stab == SW'(STABLE_CYCLES)) &&
                      ({1'b0, w_idx} != r_last_idx);

    assign w_dec = seg_decode(r_samp[6:0]);

    always_comb begin
        w_dig_ok = w_dec[4];
        if (w_idx == 3'd6)
            w_dig_ok = w_dig_ok && !r_samp[7];
        else
            w_dig_ok = w_dig_ok && r_samp[7] && (w_dec[3:0] <= 4'd1);
    end

    assign w_stale      = (r_to == TW'(TIMEOUT));
    assign w_stale_rise = w_stale && !r_stale_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_to       <= TW'(TIMEOUT);
            r_stale_d  <= 1'b1;
            r_last_idx <= 4'd8;
        end else begin
            r_stale_d <= w_stale;
            if (w_accept) begin
                r_to       <= '0;
                r_last_idx <= {1'b0, w_idx};
            end else if (!w_stale) begin
                r_to <= r_to + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= HUNT;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_store    = 1'b0;
        w_seq_err  = 1'b0;
        w_do_check = 1'b0;
        case (r_state)
            HUNT: begin
                if (w_accept && w_idx == 3'd0) begin
                    w_start = 1'b1;
                    w_next  = COLLECT;
                end
            end
            COLLECT: begin
                if (w_accept) begin
                    if (w_idx == 3'd0) begin
                        w_start = 1'b1;
                    end else if (w_idx == r_exp) begin
                        w_store = 1'b1;
                        if (w_idx == 3'd7) w_next = CHECK;
                    end else begin
                        w_seq_err = 1'b1;
                        w_next    = HUNT;
                    end
                end
            end
            CHECK: begin
                w_do_check = 1'b1;
                w_next     = HUNT;
            end
            default: w_next = HUNT;
        endcase
        // Loss of scan abandons any frame in progress.
        if (w_stale_rise) begin
            w_next    = HUNT;
            w_start   = 1'b0;
            w_store   = 1'b0;
            w_seq_err = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_jc    <= '0;
            r_units <= '0;
            r_tens  <= '0;
            r_bad   <= 1'b0;
            r_exp   <= '0;
        end else if (w_start) begin
            r_jc    <= {5'b0, w_dec[0]};
            r_units <= '0;
            r_tens  <= '0;
            r_bad   <= !w_dig_ok;
            r_exp   <= 3'd1;
        end else if (w_store) begin
            r_exp <= r_exp + 1'b1;
            r_bad <= r_bad | !w_dig_ok;
            if (w_idx == 3'd6)
                r_units <= w_dec[3:0];
            else if (w_idx == 3'd7)
                r_tens <= w_dec[3:0];
            else
                r_jc[w_idx] <= w_dec[0];
        end
    end

    assign w_sum = 8'(r_tens) * 8'd10 + 8'(r_units);

    always_comb begin
        w_jc_legal = 1'b0;
        for (int unsigned n = 0; n < 12; n++)
            if (r_jc == jc_of(4'(n))) w_jc_legal = 1'b1;
        w_chk_err = 2'b00;
        if (r_bad)
            w_chk_err = 2'b01;
        else if (w_sum > 8'd11 || !w_jc_legal)
            w_chk_err = 2'b11;
        else if (jc_of(w_sum[3:0]) != r_jc)
            w_chk_err = 2'b11;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_jc_out  <= '0;
            r_cnt_out <= '0;
            r_fv      <= 1'b0;
            r_fe      <= 1'b0;
            r_err     <= 2'b00;
        end else begin
            r_fv <= 1'b0;
            r_fe <= 1'b0;
            if (w_do_check) begin
                r_err <= w_chk_err;
                if (w_chk_err == 2'b00) begin
                    r_fv      <= 1'b1;
                    r_jc_out  <= r_jc;
                    r_cnt_out <= w_sum[3:0];
                end else begin
                    r_fe <= 1'b1;
                end
            end else if (w_seq_err) begin
                r_fe  <= 1'b1;
                r_err <= 2'b10;
            end
        end
    end

    assign bus.johnson     = r_jc_out;
    assign bus.count       = r_cnt_out;
    assign bus.frame_valid = r_fv;
    assign bus.frame_err   = r_fe;
    assign bus.err_type    = r_err;
    assign bus.stale       = w_stale;
endmodule

// File: tb/tb_display_scan_decoder.sv
// Directed bench for display_scan_decoder: drives scanned frames and checks the
// recovered count/Johnson state, error codes, staleness and reset behaviour.
module tb_display_scan_decoder;
    localparam int unsigned STABLE  = 4;
    localparam int unsigned TMO     = 300;
    localparam int unsigned HOLD    = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    display_scan_decoder_if bus();

    display_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT(TMO)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_fv    = 0;
    int n_fe    = 0;
    int n_both  = 0;

    always @(negedge clk) begin
        if (bus.frame_valid) n_fv++;
        if (bus.frame_err) n_fe++;
        if (bus.frame_valid && bus.frame_err) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg7(input int unsigned d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [5:0] jc_code(input int unsigned n);
        if (n <= 6) return 6'((1 << n) - 1);
        return 6'(6'h3F << (n - 6));
    endfunction

    // Byte k of the result is what digit k shows.
    function automatic logic [63:0] make_frame(input logic [5:0] jc, input int unsigned n);
        logic [63:0] f;
        for (int k = 0; k < 6; k++)
            f[8*k +: 8] = jc[k] ? 8'hF9 : 8'hC0;
        f[55:48] = {1'b0, seg7(n % 10)};
        f[63:56] = {1'b1, seg7(n / 10)};
        return f;
    endfunction

    task automatic show(input int idx, input logic [7:0] v, input int cycles);
        logic [7:0] c;
        c = 8'hFF;
        c[idx] = 1'b0;
        bus.control = c;
        bus.value   = v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic blank(input int cycles);
        bus.control = 8'hFF;
        bus.value   = 8'hFF;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_frame(input logic [63:0] f, input bit dead_repeat);
        for (int k = 0; k < 8; k++)
            show(k, f[8*k +: 8], HOLD);
        if (dead_repeat) begin
            blank(3);
            show(7, f[63:56], HOLD);
        end
        blank(4);
    endtask

    initial begin
        int fv0, fe0;
        logic [63:0] f;

        bus.control = 8'hFF;
        bus.value   = 8'hFF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_johnson", 32'(bus.johnson), 32'h0);
        check("rst_count", 32'(bus.count), 32'h0);
        check("rst_fv", 32'(bus.frame_valid), 32'h0);
        check("rst_fe", 32'(bus.frame_err), 32'h0);
        check("rst_err", 32'(bus.err_type), 32'h0);
        check("rst_stale", 32'(bus.stale), 32'h1);

        // Count 3, no dead-slot repeat
        fv0 = n_fv;
        send_frame(make_frame(6'b000111, 3), 1'b0);
        check("t1_pulse", 32'(n_fv - fv0), 32'd1);
        check("t1_johnson", 32'(bus.johnson), 32'h07);
        check("t1_count", 32'(bus.count), 32'd3);
        check("t1_err", 32'(bus.err_type), 32'h0);
        check("t1_stale", 32'(bus.stale), 32'h0);

        // Full sweep with digit 7 repeated across the dead slot
        fv0 = n_fv;
        for (int n = 0; n < 12; n++) begin
            send_frame(make_frame(jc_code(n), n), 1'b1);
            check($sformatf("t2_count_%0d", n), 32'(bus.count), 32'(n));
            check($sformatf("t2_jc_%0d", n), 32'(bus.johnson), 32'(jc_code(n)));
            check($sformatf("t2_err_%0d", n), 32'(bus.err_type), 32'h0);
        end
        check("t2_pulses", 32'(n_fv - fv0), 32'd12);

        // Count 8 paired with the Johnson code for 7
        fv0 = n_fv; fe0 = n_fe;
        send_frame(make_frame(6'b111110, 8), 1'b1);
        check("t3_fe", 32'(n_fe - fe0), 32'd1);
        check("t3_fv", 32'(n_fv - fv0), 32'd0);
        check("t3_err", 32'(bus.err_type), 32'h3);
        check("t3_jc_kept", 32'(bus.johnson), 32'h20);
        check("t3_cnt_kept", 32'(bus.count), 32'd11);

        // Out-of-order digit, then recovery
        fe0 = n_fe;
        f = make_frame(6'b011111, 5);
        show(0, f[7:0], HOLD);
        show(1, f[15:8], HOLD);
        show(3, f[31:24], HOLD);
        blank(4);
        check("t4_fe", 32'(n_fe - fe0), 32'd1);
        check("t4_err", 32'(bus.err_type), 32'h2);
        fv0 = n_fv;
        send_frame(f, 1'b1);
        check("t4_fv", 32'(n_fv - fv0), 32'd1);
        check("t4_count", 32'(bus.count), 32'd5);
        check("t4_err_clr", 32'(bus.err_type), 32'h0);

        // Digit 2 too short before glitching to an undecodable pattern
        fv0 = n_fv; fe0 = n_fe;
        f = make_frame(6'b000111, 3);
        show(0, f[7:0], HOLD);
        show(1, f[15:8], HOLD);
        show(2, f[23:16], STABLE - 1);
        show(2, 8'hA5, HOLD);
        for (int k = 3; k < 8; k++)
            show(k, f[8*k +: 8], HOLD);
        blank(4);
        check("t5_fe", 32'(n_fe - fe0), 32'd1);
        check("t5_fv", 32'(n_fv - fv0), 32'd0);
        check("t5_err", 32'(bus.err_type), 32'h1);
        check("t5_cnt_kept", 32'(bus.count), 32'd5);

        // Scan stops long enough to go stale
        check("t6_not_stale", 32'(bus.stale), 32'h0);
        blank(TMO + 10);
        check("t6_stale", 32'(bus.stale), 32'h1);

        // Reset in the middle of a frame
        show(0, 8'hF9, HOLD);
        show(1, 8'hF9, HOLD);
        check("t6_stale_clr", 32'(bus.stale), 32'h0);
        show(2, 8'hF9, 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_rst_johnson", 32'(bus.johnson), 32'h0);
        check("t6_rst_count", 32'(bus.count), 32'h0);
        check("t6_rst_fv", 32'(bus.frame_valid), 32'h0);
        check("t6_rst_fe", 32'(bus.frame_err), 32'h0);
        check("t6_rst_err", 32'(bus.err_type), 32'h0);
        check("t6_rst_stale", 32'(bus.stale), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        blank(2);
        fv0 = n_fv;
        send_frame(make_frame(6'b000111, 3), 1'b1);
        check("t6_after_fv", 32'(n_fv - fv0), 32'd1);
        check("t6_after_count", 32'(bus.count), 32'd3);

        check("never_both", 32'(n_both), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
